// File: rtl/pipe_stage_ctrl.sv
// DEPTH-stage pipeline register chain with operand forwarding, load-use stall and branch flush.
// Optional retire/stall/flush counters are compiled in when PIPE_PERF_EN is defined.
module pipe_stage_ctrl #(
    parameter int DEPTH       = 3,
    parameter int INSTR_W     = 32,
    parameter int CTRL_W      = 12,
    parameter int DATA_W      = 32,
    parameter int RA_W        = 5,
    parameter int ZERO_REG    = 31,
    parameter int FLUSH_DEPTH = 2,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Advance,
    input  logic                        InValid,
    input  logic [INSTR_W-1:0]          InInstr,
    input  logic [CTRL_W-1:0]           InCtrl,
    input  logic [RA_W-1:0]             InDest,
    input  logic                        InWrReg,
    input  logic                        InIsLoad,
    input  logic [RA_W-1:0]             InRs1,
    input  logic [RA_W-1:0]             InRs2,
    input  logic [DATA_W-1:0]           ExResult,
    input  logic [DATA_W-1:0]           MemData,
    input  logic                        Flush,
    output logic                        InReady,
    output logic [DEPTH-1:0]            StageValid,
    output logic [DEPTH*INSTR_W-1:0]    StageInstr,
    output logic [DEPTH*CTRL_W-1:0]     StageCtrl,
    output logic [DEPTH*DATA_W-1:0]     StageResult,
    output logic [SEL_W-1:0]            Fwd1Sel,
    output logic [SEL_W-1:0]            Fwd2Sel,
    output logic [DATA_W-1:0]           Fwd1Data,
    output logic [DATA_W-1:0]           Fwd2Data,
`ifdef PIPE_PERF_EN
    output logic [15:0]                 RetireCnt,
    output logic [15:0]                 StallCnt,
    output logic [15:0]                 FlushCnt,
`endif
    output logic                        Stall
);

    localparam int FLUSH_LIM = (FLUSH_DEPTH < DEPTH) ? FLUSH_DEPTH : DEPTH;
    localparam logic [RA_W-1:0] ZERO_RA = RA_W'(ZERO_REG);

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   wr_q, wr_d;
    logic [DEPTH-1:0]   load_q, load_d;
    logic [INSTR_W-1:0] instr_q  [DEPTH];
    logic [INSTR_W-1:0] instr_d  [DEPTH];
    logic [CTRL_W-1:0]  ctrl_q   [DEPTH];
    logic [CTRL_W-1:0]  ctrl_d   [DEPTH];
    logic [RA_W-1:0]    dest_q   [DEPTH];
    logic [RA_W-1:0]    dest_d   [DEPTH];
    logic [DATA_W-1:0]  result_q [DEPTH];
    logic [DATA_W-1:0]  result_d [DEPTH];

    logic [DEPTH-1:0]   hit1, hit2;

    // Per-stage hazard match and output packing.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        assign hit1[gi] = valid_q[gi] && wr_q[gi] && (dest_q[gi] == InRs1) && (InRs1 != ZERO_RA);
        assign hit2[gi] = valid_q[gi] && wr_q[gi] && (dest_q[gi] == InRs2) && (InRs2 != ZERO_RA);
        assign StageInstr[gi*INSTR_W +: INSTR_W] = instr_q[gi];
        assign StageCtrl[gi*CTRL_W +: CTRL_W]    = ctrl_q[gi];
        assign StageResult[gi*DATA_W +: DATA_W]  = result_q[gi];
    end

    assign StageValid = valid_q;
    assign Stall      = InValid && load_q[0] && (hit1[0] || hit2[0]);
    assign InReady    = !Stall || Flush;

    // Oldest stages are visited first so that younger matches overwrite them.
    always_comb begin
        Fwd1Sel  = '0;
        Fwd1Data = '0;
        Fwd2Sel  = '0;
        Fwd2Data = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (hit1[k]) begin
                Fwd1Sel  = SEL_W'(k + 1);
                Fwd1Data = result_q[k];
            end
            if (hit2[k]) begin
                Fwd2Sel  = SEL_W'(k + 1);
                Fwd2Data = result_q[k];
            end
        end
        if (hit1[0] && !load_q[0]) begin
            Fwd1Sel  = SEL_W'(1);
            Fwd1Data = ExResult;
        end
        if (hit2[0] && !load_q[0]) begin
            Fwd2Sel  = SEL_W'(1);
            Fwd2Data = ExResult;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        wr_d     = wr_q;
        load_d   = load_q;
        instr_d  = instr_q;
        ctrl_d   = ctrl_q;
        dest_d   = dest_q;
        result_d = result_q;
        if (Advance) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                valid_d[k]  = valid_q[k-1];
                wr_d[k]     = wr_q[k-1];
                load_d[k]   = load_q[k-1];
                instr_d[k]  = instr_q[k-1];
                ctrl_d[k]   = ctrl_q[k-1];
                dest_d[k]   = dest_q[k-1];
                result_d[k] = result_q[k-1];
            end
            result_d[1] = load_q[0] ? MemData : ExResult;
            // A refused instruction turns into an all-zero bubble.
            valid_d[0]  = InReady && InValid;
            wr_d[0]     = InReady && InWrReg;
            load_d[0]   = InReady && InIsLoad;
            instr_d[0]  = InReady ? InInstr : '0;
            ctrl_d[0]   = InReady ? InCtrl  : '0;
            dest_d[0]   = InReady ? InDest  : '0;
            result_d[0] = '0;
        end
        if (Flush) begin
            for (int k = 0; k < FLUSH_LIM; k++) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            valid_q  <= '0;
            wr_q     <= '0;
            load_q   <= '0;
            instr_q  <= '{default: '0};
            ctrl_q   <= '{default: '0};
            dest_q   <= '{default: '0};
            result_q <= '{default: '0};
        end else begin
            valid_q  <= valid_d;
            wr_q     <= wr_d;
            load_q   <= load_d;
            instr_q  <= instr_d;
            ctrl_q   <= ctrl_d;
            dest_q   <= dest_d;
            result_q <= result_d;
        end
    end

`ifdef PIPE_PERF_EN
    logic [15:0] retire_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (Advance && valid_q[DEPTH-1] && retire_cnt_q != 16'hFFFF)
                retire_cnt_q <= retire_cnt_q + 16'd1;
            if (Advance && Stall && !Flush && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (Flush && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign RetireCnt = retire_cnt_q;
    assign StallCnt  = stall_cnt_q;
    assign FlushCnt  = flush_cnt_q;
`endif

endmodule
